// File: rtl/pwm_sampler_mc.sv
// Multi-channel PWM audio sampler: frame FIFO feeding per-channel edge/center-aligned PWM,
// one frame consumed per sample period, codes swapped only on PWM window boundaries.
module pwm_sampler_mc #(
  parameter int unsigned NUM_CH            = 2,
  parameter int unsigned CODE_WIDTH        = 10,
  parameter int unsigned CYCLES_PER_SAMPLE = 2500,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           center_mode,
  input  logic                           in_valid,
  input  logic [NUM_CH*CODE_WIDTH-1:0]   in_data,
  output logic                           in_ready,
  input  logic                           underflow_clr,
  output logic [NUM_CH-1:0]              pwm_out,
  output logic                           sample_tick,
  output logic                           underflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int unsigned FrameW = NUM_CH * CODE_WIDTH;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SampW  = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;

  localparam logic [SampW-1:0]    SampLast = SampW'(CYCLES_PER_SAMPLE - 1);
  localparam logic [CntW-1:0]     CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [CODE_WIDTH:0] WinSize  = {1'b1, {CODE_WIDTH{1'b0}}};

  logic [FrameW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  rdy_en_q;
  logic [SampW-1:0]      samp_q, samp_d;
  logic [CODE_WIDTH-1:0] win_q, win_d;
  logic [FrameW-1:0]     pend_q, pend_d;
  logic [FrameW-1:0]     act_q, act_d;
  logic                  center_q, center_d;
  logic                  underflow_q, underflow_d;
  logic [NUM_CH-1:0]     pwm_q, pwm_d;
  logic                  push, pop, tick, win_last;

  // rdy_en_q keeps in_ready low until the first clock after reset release.
  assign in_ready = rdy_en_q && (count_q < CntFull);
  assign push     = in_valid && in_ready;
  assign tick     = enable && (samp_q == SampLast);
  assign pop      = tick && (count_q != '0);
  assign win_last = enable && (win_q == '1);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    samp_d = '0;
    if (enable) begin
      samp_d = tick ? '0 : samp_q + SampW'(1);
    end
    win_d = enable ? win_q + CODE_WIDTH'(1) : '0;

    pend_d   = pop ? mem_q[rptr_q] : pend_q;
    act_d    = win_last ? pend_q : act_q;
    center_d = win_last ? center_mode : center_q;

    // A set in the same cycle as a clear takes priority.
    if (tick && (count_q == '0)) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CODE_WIDTH:0] code, win, lo, hi;
    assign code = {1'b0, act_q[c*CODE_WIDTH +: CODE_WIDTH]};
    assign win  = {1'b0, win_q};
    assign lo   = (WinSize - code) >> 1;
    assign hi   = lo + code;
    assign pwm_d[c] = enable && (center_q ? ((lo <= win) && (win < hi)) : (win < code));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdy_en_q    <= 1'b0;
      samp_q      <= '0;
      win_q       <= '0;
      pend_q      <= '0;
      act_q       <= '0;
      center_q    <= 1'b0;
      underflow_q <= 1'b0;
      pwm_q       <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q     <= count_d;
      rdy_en_q    <= 1'b1;
      samp_q      <= samp_d;
      win_q       <= win_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      center_q    <= center_d;
      underflow_q <= underflow_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign sample_tick = tick;
  assign underflow   = underflow_q;
  assign fifo_count  = count_q;

endmodule
